seq_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider. It is the inverse arithmetic counterpart of the team's ripple add/subtract datapath.
- Each iteration performs one trial subtraction using the same two's-complement scheme: invert the subtrahend, carry-in = 1, carry-out = 1 means no borrow.
- Produces quotient and remainder one bit per clock, behind a start/busy/done handshake, for use alongside the adder blocks in the arithmetic library.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_trial_sub.sv | 27 ++
 rtl/full_adder.sv | 13 +
 rtl/seq_restoring_divider.sv | 124 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } div_state_e;

   // Iteration counter width; at least one bit so WIDTH=2 still has a counter.
   function automatic int cnt_w(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Ripple trial subtractor: a - b as a + ~b + 1; carry-out high means no borrow.
module div_trial_sub #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         no_borrow
);

   logic [W:0] w_carry;

   assign w_carry[0] = 1'b1;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      full_adder u_fa (
         .a    (a[gi]),
         .b    (~b[gi]),
         .cin  (w_carry[gi]),
         .sum  (diff[gi]),
         .cout (w_carry[gi+1])
      );
   end

   assign no_borrow = w_carry[W];

endmodule

// File: rtl/full_adder.sv
// 1-bit full-adder cell from the arithmetic library.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// behind a start/busy/done handshake.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_w(WIDTH);

   div_state_e       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_prem;
   logic [WIDTH-1:0] r_quo;
   logic             r_zdiv;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_next;
   logic             w_nb;
   logic             w_unused;

   // r_dvd shifts left during RUN so its MSB is always the next dividend bit.
   assign w_shift = {r_prem, r_dvd[WIDTH-1]};

   div_trial_sub #(.W(WIDTH + 1)) u_trial (
      .a         (w_shift),
      .b         ({1'b0, r_dvs}),
      .diff      (w_diff),
      .no_borrow (w_nb)
   );

   // Either branch is below the divisor afterwards, so the top bit is always 0.
   assign w_next   = w_nb ? w_diff : w_shift;
   assign w_unused = w_next[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_dvd         <= '0;
         r_dvs         <= '0;
         r_prem        <= '0;
         r_quo         <= '0;
         r_zdiv        <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd  <= dividend;
                  r_dvs  <= divisor;
                  r_prem <= '0;
                  r_quo  <= '0;
                  r_cnt  <= CW'(WIDTH - 1);
                  if (divisor == '0) begin
                     r_zdiv  <= 1'b1;
                     r_state <= FINISH;
                  end else begin
                     r_zdiv  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_prem <= w_next[WIDTH-1:0];
               r_quo  <= {r_quo[WIDTH-2:0], w_nb};
               r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= FINISH;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            FINISH: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
               if (r_zdiv) begin
                  r_quotient    <= '1;
                  r_remainder   <= r_dvd;
                  r_div_by_zero <= 1'b1;
               end else begin
                  r_quotient    <= r_quo;
                  r_remainder   <= r_prem;
                  r_div_by_zero <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: latency/handshake model with plain / and %, per-cycle compare,
// directed literal cases, exhaustive sweep and randomized traffic.
module tb_seq_restoring_divider;

   localparam int WIDTH = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an accepted op completes after a fixed number of clocks, results from / and %.
   int   m_left;
   int   m_pq, m_pr, m_pdz;
   int   m_q, m_r, m_dz;
   logic m_done;
   logic m_zop;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0; m_done <= 1'b0; m_zop <= 1'b0;
         m_q <= 0; m_r <= 0; m_dz <= 0;
         m_pq <= 0; m_pr <= 0; m_pdz <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_left == 0 && start) begin
            m_zop  <= (divisor == 0);
            m_left <= (divisor == 0) ? 1 : WIDTH + 1;
            m_pq   <= (divisor == 0) ? MAXV : int'(dividend) / int'(divisor);
            m_pr   <= (divisor == 0) ? int'(dividend) : int'(dividend) % int'(divisor);
            m_pdz  <= (divisor == 0) ? 1 : 0;
         end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_done <= 1'b1;
               m_q <= m_pq; m_r <= m_pr; m_dz <= m_pdz;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", int'(busy), (m_left >= 2 && !m_zop) ? 1 : 0);
         chk("done", int'(done), int'(m_done));
         chk("quotient", int'(quotient), m_q);
         chk("remainder", int'(remainder), m_r);
         chk("div_by_zero", int'(div_by_zero), m_dz);
         if (done) n_done++;
      end
   end

   // Issue one op from mid-cycle; returns clocks from the sampling edge to done and busy cycles.
   task automatic do_op(input int a, input int b, output int lat, output int nb);
      dividend = WIDTH'(a); divisor = WIDTH'(b); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = 0; nb = int'(busy);
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++; nb += int'(busy);
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic op_lit(input string nm, input int a, input int b,
                         input int eq, input int er, input int edz, input int elat);
      int lat, nb;
      do_op(a, b, lat, nb);
      chk({nm, "_q"}, int'(quotient), eq);
      chk({nm, "_r"}, int'(remainder), er);
      chk({nm, "_dz"}, int'(div_by_zero), edz);
      chk({nm, "_lat"}, lat, elat);
      chk({nm, "_busycyc"}, nb, (edz != 0) ? 0 : WIDTH);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
      $fatal(1);
   end

   initial begin
      int lat, nb, d0;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_q", int'(quotient), 0);
      chk("rst_r", int'(remainder), 0);
      chk("rst_dz", int'(div_by_zero), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      op_lit("basic_13_3", 13, 3, 4, 1, 0, 5);
      op_lit("edge_15_1", 15, 1, 15, 0, 0, 5);
      op_lit("edge_15_15", 15, 15, 1, 0, 0, 5);
      op_lit("edge_0_7", 0, 7, 0, 0, 0, 5);
      op_lit("small_7_9", 7, 9, 0, 7, 0, 5);
      op_lit("zero_9_0", 9, 0, 15, 9, 1, 1);
      op_lit("after_zero_8_2", 8, 2, 4, 0, 0, 5);

      // Start held through RUN and FINISH with other operands: must be ignored.
      dividend = 4'd13; divisor = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      d0 = n_done;
      dividend = 4'd6; divisor = 4'd2;
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("hs_done_count", n_done - d0, 1);
      chk("hs_q", int'(quotient), 4);
      chk("hs_r", int'(remainder), 1);
      op_lit("hs_6_2", 6, 2, 3, 0, 0, 5);

      // Asynchronous reset between edges, two cycles into RUN.
      dividend = 4'd14; divisor = 4'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_q", int'(quotient), 0);
      chk("midrst_r", int'(remainder), 0);
      chk("midrst_dz", int'(div_by_zero), 0);
      d0 = n_done;
      @(posedge clk); #2 rst = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      chk("midrst_no_done", n_done - d0, 0);
      op_lit("post_rst_14_3", 14, 3, 4, 2, 0, 5);

      for (int a = 0; a <= MAXV; a++) begin
         for (int b = 0; b <= MAXV; b++) begin
            do_op(a, b, lat, nb);
            if (b != 0) begin
               chk("sweep_identity", int'(quotient) * b + int'(remainder), a);
               chk("sweep_rem_lt_div", (int'(remainder) < b) ? 1 : 0, 1);
               chk("sweep_lat", lat, WIDTH + 1);
            end else begin
               chk("sweep_z_q", int'(quotient), MAXV);
               chk("sweep_z_r", int'(remainder), a);
               chk("sweep_z_lat", lat, 1);
            end
         end
      end

      // Random traffic, including start pulses while busy; the per-cycle compare checks it.
      repeat (2000) begin
         @(posedge clk); #1;
         start    = ($urandom_range(0, 2) == 0);
         dividend = WIDTH'($urandom_range(0, MAXV));
         divisor  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, MAXV));
      end
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
